// File: rtl/game_pkg.sv
// Shared constants for the game front end: clock rate and the default
// debounce window (10 ms at the 25 MHz pixel clock).
package game_pkg;

  localparam int VGA_CLOCK_HZ            = 25_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

endpackage

// File: rtl/debounce_channel.sv
// One raw pin -> two-flop synchroniser -> counter debouncer -> press strobe.
// Active-low pins are inverted on entry so everything downstream means "1 = on/pressed".
module debounce_channel
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             pin;
  logic             s1;
  logic             s2;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic             pulse;

  assign pin = ACTIVE_LOW ? ~raw : raw;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      s1    <= pin;
      s2    <= s1;
      pulse <= 1'b0;
      // A single agreeing sample restarts the window, so short glitches never land.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db    <= s2;
        cnt   <= '0;
        pulse <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level       = db;
  assign press_pulse = pulse;

endmodule

// File: rtl/input_conditioner.sv
// Cleans the raw board pins into debounced levels and press strobes in the
// vga_clock domain; the four channels are fully independent.
module input_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic vga_clock,
  input  logic reset,
  input  logic left_switch_raw,
  input  logic right_switch_raw,
  input  logic jump_button_raw,
  input  logic start_button_raw,
  output logic left_switch,
  output logic right_switch,
  output logic jump_held,
  output logic start_held,
  output logic jump_pulse,
  output logic start_pulse
);

  // Switch press strobes are not needed downstream and are left for synthesis to prune.
  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0), .CNT_W(CNT_W)) u_left (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .raw        (left_switch_raw),
    .level      (left_switch),
    .press_pulse()
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b0), .CNT_W(CNT_W)) u_right (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .raw        (right_switch_raw),
    .level      (right_switch),
    .press_pulse()
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1), .CNT_W(CNT_W)) u_jump (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .raw        (jump_button_raw),
    .level      (jump_held),
    .press_pulse(jump_pulse)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE_LOW(1'b1), .CNT_W(CNT_W)) u_start (
    .vga_clock  (vga_clock),
    .reset      (reset),
    .raw        (start_button_raw),
    .level      (start_held),
    .press_pulse(start_pulse)
  );

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=8: stimulus posts
// hand-computed expectations keyed by edge number, a negedge monitor checks them.
module tb_input_conditioner;

  localparam int D = 8;

  // Output vector bit order: {left, right, jump_held, start_held, jump_pulse, start_pulse}
  localparam logic [5:0] M_ALL = 6'b111111;
  localparam logic [5:0] B_L   = 6'b100000;
  localparam logic [5:0] B_R   = 6'b010000;
  localparam logic [5:0] B_JH  = 6'b001000;
  localparam logic [5:0] B_SH  = 6'b000100;
  localparam logic [5:0] B_JP  = 6'b000010;
  localparam logic [5:0] B_SP  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_raw = 1'b0, right_raw = 1'b0, jump_raw = 1'b1, start_raw = 1'b0;
  logic left_switch, right_switch, jump_held, start_held, jump_pulse, start_pulse;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .vga_clock       (clk),
    .reset           (rst),
    .left_switch_raw (left_raw),
    .right_switch_raw(right_raw),
    .jump_button_raw (jump_raw),
    .start_button_raw(start_raw),
    .left_switch     (left_switch),
    .right_switch    (right_switch),
    .jump_held       (jump_held),
    .start_held      (start_held),
    .jump_pulse      (jump_pulse),
    .start_pulse     (start_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [5:0] mask;
    logic [5:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   jp_count = 0;

  task automatic expect_at(input int at, input logic [5:0] mask, input logic [5:0] val, input string name);
    exp_t e;
    e.at = at; e.mask = mask; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every expectation that falls due on this edge.
  always @(negedge clk) begin
    logic [5:0] outs;
    outs = {left_switch, right_switch, jump_held, start_held, jump_pulse, start_pulse};
    if (jump_pulse) jp_count = jp_count + 1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        tests = tests + 1;
        if (((outs ^ sb[i].val) & sb[i].mask) != 6'b0) begin
          fails = fails + 1;
          $display("FAIL %s edge=%0d got=%b expected=%b mask=%b",
                   sb[i].name, cyc, outs, sb[i].val, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int e;
    int jp0;

    // Reset with start held pressed: all low during reset, then a press after release.
    step(1);
    expect_at(cyc + 1, M_ALL, 6'b0, "reset_hold_a");
    expect_at(cyc + 2, M_ALL, 6'b0, "reset_hold_b");
    step(3);
    rst = 1'b0; e = cyc;
    expect_at(e + 1,  M_ALL, 6'b0, "post_reset_first_edge");
    expect_at(e + 9,  M_ALL, 6'b0, "start_before_rise");
    expect_at(e + 10, M_ALL, B_SH | B_SP, "start_rise_pulse");
    expect_at(e + 11, M_ALL, B_SH, "start_pulse_one_cycle");
    step(12);
    start_raw = 1'b1; e = cyc;
    expect_at(e + 9,  B_SH | B_SP, B_SH, "start_release_pending");
    expect_at(e + 10, M_ALL, 6'b0, "start_release_no_pulse");
    expect_at(e + 11, M_ALL, 6'b0, "start_release_settled");
    step(12);

    // Clean jump press and release.
    jump_raw = 1'b0; e = cyc;
    expect_at(e + 9,  B_JH | B_JP, 6'b0, "jump_before_rise");
    expect_at(e + 10, M_ALL, B_JH | B_JP, "jump_rise_pulse");
    expect_at(e + 11, M_ALL, B_JH, "jump_pulse_one_cycle");
    step(15);
    jump_raw = 1'b1; e = cyc;
    expect_at(e + 9,  B_JH | B_JP, B_JH, "jump_release_pending");
    expect_at(e + 10, M_ALL, 6'b0, "jump_release_no_pulse");
    expect_at(e + 11, M_ALL, 6'b0, "jump_release_settled");
    step(12);

    // Bounce: 7 high / 1 low, five times; counter reaches D-1 and is cleared each time.
    for (int b = 0; b < 5; b++) begin
      left_raw = 1'b1; e = cyc;
      expect_at(e + 8,  B_L, 6'b0, "bounce_at_max_count");
      expect_at(e + 9,  B_L, 6'b0, "bounce_cleared");
      expect_at(e + 10, B_L, 6'b0, "bounce_still_low");
      step(7);
      left_raw = 1'b0;
      step(1);
    end
    left_raw = 1'b1; e = cyc;
    expect_at(e + 9,  B_L, 6'b0, "bounce_final_before");
    expect_at(e + 10, M_ALL, B_L, "bounce_final_rise");
    step(12);
    left_raw = 1'b0; e = cyc;
    expect_at(e + 10, M_ALL, 6'b0, "left_release");
    step(12);

    // Reset mid-count on the right switch.
    right_raw = 1'b1;
    step(6);
    rst = 1'b1;
    expect_at(cyc, M_ALL, 6'b0, "midcount_reset_clears");
    expect_at(cyc + 1, M_ALL, 6'b0, "midcount_reset_hold");
    step(2);
    rst = 1'b0; e = cyc;
    expect_at(e + 9,  M_ALL, 6'b0, "midcount_restart_before");
    expect_at(e + 10, M_ALL, B_R, "midcount_restart_rise");
    step(12);
    right_raw = 1'b0; e = cyc;
    expect_at(e + 10, M_ALL, 6'b0, "right_release");
    step(12);

    // All four pins at once.
    left_raw = 1'b1; right_raw = 1'b1; jump_raw = 1'b0; start_raw = 1'b0; e = cyc;
    expect_at(e + 9,  M_ALL, 6'b0, "simul_before");
    expect_at(e + 10, M_ALL, 6'b111111, "simul_rise");
    expect_at(e + 11, M_ALL, 6'b111100, "simul_pulses_end");
    step(12);
    left_raw = 1'b0; right_raw = 1'b0; jump_raw = 1'b1; start_raw = 1'b1; e = cyc;
    expect_at(e + 9,  M_ALL, 6'b111100, "simul_release_before");
    expect_at(e + 10, M_ALL, 6'b0, "simul_release");
    step(12);

    // Three clean presses separated by 20-cycle releases.
    jp0 = jp_count;
    for (int p = 0; p < 3; p++) begin
      jump_raw = 1'b0; e = cyc;
      expect_at(e + 9,  B_JP, 6'b0, "repeat_before");
      expect_at(e + 10, B_JH | B_JP, B_JH | B_JP, "repeat_pulse");
      expect_at(e + 11, B_JH | B_JP, B_JH, "repeat_pulse_end");
      step(12);
      jump_raw = 1'b1;
      step(20);
    end
    tests = tests + 1;
    if (jp_count - jp0 != 3) begin
      fails = fails + 1;
      $display("FAIL repeat_pulse_count got=%0d expected=3", jp_count - jp0);
    end

    step(5);
    while (sb.size() > 0) begin
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL %s never_checked at=%0d now=%0d", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that sits directly upstream of the game-state top level. It takes the raw board pins (left/right slide switches, active-low jump and start push-buttons) and makes them clean. Each pin is synchronised into the `vga_clock` domain and debounced. The block emits stable active-high levels plus single-cycle press pulses. The top-level FSM and the level drawers consume these outputs in place of raw pins.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000 (10 ms at 25 MHz): consecutive stable cycles required before a debounced output changes. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of the debounce counter. Derived; never overridden.

Ports:
- `vga_clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `left_switch_raw` in 1: raw slide switch, 1 = on.
- `right_switch_raw` in 1: raw slide switch, 1 = on.
- `jump_button_raw` in 1: raw push-button, active-low (0 = pressed).
- `start_button_raw` in 1: raw push-button, active-low (0 = pressed).
- `left_switch` out 1: debounced level, 1 = on.
- `right_switch` out 1: debounced level, 1 = on.
- `jump_held` out 1: debounced level, 1 = jump pressed.
- `start_held` out 1: debounced level, 1 = start pressed.
- `jump_pulse` out 1: one-cycle strobe on each debounced jump press.
- `start_pulse` out 1: one-cycle strobe on each debounced start press.

## Operation
- Four identical channels, one per raw input.
- Button channels invert their input at the pin, so all internal logic is active-high. "Pressed" = 1.
- Each channel has three stages:
  - Sync: a two-flop synchroniser `s1` → `s2`.
  - Debounce: a state bit `db` and a counter `cnt` of width `CNT_W`.
  - Edge detect: a registered `pulse`.
- Debounce rule, evaluated every clock:
  - If `s2 == db`: `cnt` ← 0.
  - If `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db` ← `s2` and `cnt` ← 0.
  - Otherwise: `cnt` ← `cnt + 1`.
- Any single matching sample clears `cnt`. A glitch shorter than `DEBOUNCE_CYCLES` therefore never reaches `db`.
- The counter never wraps. Its maximum value is `DEBOUNCE_CYCLES-1`.
- `pulse` is registered. It is set on the same edge that `db` flips 0→1 and is cleared on the next edge.
- A 1→0 flip (release) produces no pulse.
- Switch channels have their `pulse` output left unconnected. The synthesis tool prunes it.
- Outputs per channel:
  - `left_switch` / `right_switch` / `jump_held` / `start_held` = the channel's `db`.
  - `jump_pulse` / `start_pulse` = the channel's `pulse`.

## Timing
- Reset values, applied asynchronously:
  - `s1`, `s2`, `db`, `cnt`, `pulse` = 0 in every channel.
  - Because buttons are inverted at the pin, a 0 here means "released".
  - Consequently every output is 0 while reset is high and on the first edge after release.
- Latency: if a raw pin changes before edge k and stays stable, the output changes after edge k+1+`DEBOUNCE_CYCLES`.
  - Edges k and k+1 fill the synchroniser.
  - The debounce counter sees mismatches on edges k+2 … k+1+`DEBOUNCE_CYCLES`.
- `*_pulse` is high for exactly the one cycle that begins at the edge where `*_held` rises.
- Boundary cases:
  - A pin held pressed through reset release: the output rises `DEBOUNCE_CYCLES`+2 edges after reset deasserts, and the pulse fires. The start FSM must tolerate this.
  - A bounce that returns to the old level on the very cycle `cnt` would have reached `DEBOUNCE_CYCLES-1`: `cnt` clears and `db` does not flip.
  - Reset asserted mid-count: all state clears immediately and no pulse is emitted.
  - Simultaneous changes on several pins are independent. Channels share nothing.

## Structure
- The shared package `game_pkg` holds `DEBOUNCE_CYCLES_DEFAULT` (250000) and the `VGA_CLOCK_HZ` constant (25_000_000).
- Sub-module `debounce_channel` has:
  - Parameters `DEBOUNCE_CYCLES`, `ACTIVE_LOW`.
  - Ports `vga_clock`, `reset`, `raw`, `level`, `press_pulse`.
- `input_conditioner` instantiates `debounce_channel` four times:
  - `ACTIVE_LOW=1` for the jump and start buttons.
  - `ACTIVE_LOW=0` for the two switches.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=8`.
- Reset → assert reset while `start_button_raw=0` (pressed) → all outputs 0 during reset. After release, `start_held`=1 and `start_pulse`=1 for one cycle, both after edge 10 post-reset.
- Clean press → `jump_button_raw` drops to 0 before edge 0 and holds → `jump_held` rises after edge 9; `jump_pulse` is high only in the cycle after edge 9; release produces no pulse.
- Bounce → `left_switch_raw` toggles 1 for 7 cycles, 0 for 1 cycle, repeated 5 times, then held at 1 → `left_switch` stays 0 during the toggling, then rises 10 edges after the final 0→1.
- Reset mid-count → raise `right_switch_raw`, then assert reset at edge 6 for 2 cycles → `right_switch` remains 0 and the counter restarts. The output rises 10 edges after reset deasserts.
- Simultaneous → all four raw pins change on the same edge → all four `*_held` outputs change after the same edge (k+9); `jump_pulse` and `start_pulse` are coincident.
- Repeat presses → 3 clean jump presses separated by 20-cycle releases → exactly 3 `jump_pulse` strobes, each 1 cycle wide.
